// File: rtl/i2s_pkg.sv
// Shared constants and encodings for the PmodI2S2 frame sequencer.
`timescale 1ns/1ps
package i2s_pkg;

   localparam int CNT_W  = 11;
   localparam int PH_W   = 5;
   localparam int SLOT_W = 5;

   localparam logic [PH_W-1:0] PH_SAMPLE = 5'd20;
   localparam logic [PH_W-1:0] PH_DRIVE  = 5'd0;

   typedef enum logic {
      LEFT  = 1'b0,
      RIGHT = 1'b1
   } half_t;

endpackage

// File: rtl/i2s_clkgen.sv
// Frame counter and registered MCLK/SCLK/LRCK generation for the I2S master.
`timescale 1ns/1ps
module i2s_clkgen
   import i2s_pkg::*;
(
   input  logic              clk100,
   input  logic              rst,
   input  logic              en,
   output logic [PH_W-1:0]   ph,
   output logic [SLOT_W-1:0] slot,
   output logic              half,
   output logic              run,
   output logic              frame_start,
   output logic              mclk,
   output logic              sclk,
   output logic              lrck
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;

   always_comb begin
      run      = en & ~rst;
      cnt_next = en ? cnt + 1'b1 : '0;
   end

   // Clocks are taken from the next count so each one lines up with cnt in the same cycle.
   always_ff @(posedge clk100) begin
      if (rst) begin
         cnt  <= '0;
         mclk <= 1'b0;
         sclk <= 1'b0;
         lrck <= 1'b0;
      end else begin
         cnt  <= cnt_next;
         mclk <= cnt_next[1];
         sclk <= cnt_next[4];
         lrck <= cnt_next[10];
      end
   end

   assign ph          = cnt[PH_W-1:0];
   assign slot        = cnt[CNT_W-2:PH_W];
   assign half        = cnt[CNT_W-1];
   assign frame_start = run && (cnt == '0);

endmodule

// File: rtl/i2s_frame_ctrl.sv
// I2S master for the PmodI2S2: ADC frame deserialiser and handshaked DAC serialiser.
`timescale 1ns/1ps
module i2s_frame_ctrl
   import i2s_pkg::*;
#(
   parameter int DATA_W      = 24,
   parameter int SYNC_STAGES = 2
)(
   input  logic              clk100,
   input  logic              rst,
   input  logic              en,
   output logic              mclk,
   output logic              sclk,
   output logic              lrck,
   input  logic              adc_sdata,
   output logic              dac_sdata,
   output logic [DATA_W-1:0] rx_l,
   output logic [DATA_W-1:0] rx_r,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_l,
   input  logic [DATA_W-1:0] tx_r,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              underrun
);

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(DATA_W);

   logic [PH_W-1:0]        ph;
   logic [SLOT_W-1:0]      slot;
   logic                   half;
   logic                   run;
   logic                   frame_start;
   half_t                  cur_half;
   logic                   data_slot;
   logic                   rx_sample;
   logic                   rx_last;
   logic [SYNC_STAGES-1:0] sync;
   logic [DATA_W:0]        shift_in;
   logic [DATA_W-1:0]      rx_shift;
   logic [DATA_W-1:0]      rx_stage;
   logic [DATA_W-1:0]      hold_l;
   logic [DATA_W-1:0]      hold_r;
   logic                   hold_full;
   logic                   accept;
   logic [DATA_W-1:0]      sh_l;
   logic [DATA_W-1:0]      sh_r;
   logic [DATA_W-1:0]      tx_word;
   logic [DATA_W-1:0]      tx_aligned;

   i2s_clkgen u_clkgen (
      .clk100      (clk100),
      .rst         (rst),
      .en          (en),
      .ph          (ph),
      .slot        (slot),
      .half        (half),
      .run         (run),
      .frame_start (frame_start),
      .mclk        (mclk),
      .sclk        (sclk),
      .lrck        (lrck)
   );

   assign cur_half   = half_t'(half);
   assign data_slot  = (slot != '0) && (slot <= LAST_SLOT);
   assign rx_sample  = run && (ph == PH_SAMPLE) && data_slot;
   assign rx_last    = rx_sample && (slot == LAST_SLOT);
   assign shift_in   = {rx_shift, sync[SYNC_STAGES-1]};
   assign accept     = tx_valid & ~hold_full;
   assign tx_ready   = ~hold_full;
   assign tx_word    = (cur_half == LEFT) ? sh_l : sh_r;
   assign tx_aligned = tx_word << (slot - 1'b1);

   always_ff @(posedge clk100) begin
      if (rst) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], adc_sdata};
      end
   end

   // Left word parks in staging so both channels publish together at the end of the right half.
   always_ff @(posedge clk100) begin
      if (rst) begin
         rx_shift <= '0;
         rx_stage <= '0;
         rx_l     <= '0;
         rx_r     <= '0;
         rx_valid <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (rx_sample) begin
            rx_shift <= shift_in[DATA_W-1:0];
         end
         if (rx_last && (cur_half == LEFT)) begin
            rx_stage <= shift_in[DATA_W-1:0];
         end
         if (rx_last && (cur_half == RIGHT)) begin
            rx_l     <= rx_stage;
            rx_r     <= shift_in[DATA_W-1:0];
            rx_valid <= 1'b1;
         end
      end
   end

   // A word accepted on the frame_start cycle cannot be full yet, so that frame underruns.
   always_ff @(posedge clk100) begin
      if (rst) begin
         hold_l    <= '0;
         hold_r    <= '0;
         hold_full <= 1'b0;
         sh_l      <= '0;
         sh_r      <= '0;
         underrun  <= 1'b0;
         dac_sdata <= 1'b0;
      end else begin
         underrun <= 1'b0;
         if (frame_start) begin
            if (hold_full) begin
               sh_l <= hold_l;
               sh_r <= hold_r;
            end else begin
               sh_l     <= '0;
               sh_r     <= '0;
               underrun <= 1'b1;
            end
         end
         if (accept) begin
            hold_l    <= tx_l;
            hold_r    <= tx_r;
            hold_full <= 1'b1;
         end else if (frame_start) begin
            hold_full <= 1'b0;
         end
         if (!run) begin
            dac_sdata <= 1'b0;
         end else if (ph == PH_DRIVE) begin
            dac_sdata <= data_slot ? tx_aligned[DATA_W-1] : 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Directed/randomised bench for i2s_frame_ctrl with edge-driven ADC model and DAC decoder.
`timescale 1ns/1ps
module tb_i2s_frame_ctrl;

   localparam int DATA_W      = 24;
   localparam int FRAME       = 2048;
   localparam int RX_DONE_CNT = 1024 + DATA_W * 32 + 20 + 1;

   logic              clk100    = 1'b0;
   logic              rst       = 1'b1;
   logic              en        = 1'b0;
   logic              adc_sdata = 1'b0;
   logic [DATA_W-1:0] tx_l      = '0;
   logic [DATA_W-1:0] tx_r      = '0;
   logic              tx_valid  = 1'b0;
   logic              mclk, sclk, lrck, dac_sdata, rx_valid, tx_ready, underrun;
   logic [DATA_W-1:0] rx_l, rx_r;

   int tests  = 0;
   int failed = 0;
   int cur    = 0;
   bit check_on = 1'b0;
   bit model_on = 1'b0;
   int clk_err = 0, rx_seen = 0, rx_err = 0, ur_seen = 0, ur_err = 0, zero_err = 0;

   logic [DATA_W-1:0]   adc_l_words [8];
   logic [DATA_W-1:0]   adc_r_words [8];
   logic [2*DATA_W-1:0] rx_exp[$];
   logic [2*DATA_W-1:0] dac_exp[$];
   logic [2*DATA_W-1:0] dac_got[$];
   logic [2*DATA_W-1:0] rx_want;

   int                adc_pos   = 0;
   int                adc_frame = 0;
   logic              adc_half  = 1'b0;
   int                dac_pos   = 0;
   logic              dac_half  = 1'b1;
   logic [DATA_W-1:0] dac_lw    = '0;
   logic [DATA_W-1:0] dac_rw    = '0;

   always #5 clk100 = ~clk100;

   i2s_frame_ctrl #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
      .clk100    (clk100),
      .rst       (rst),
      .en        (en),
      .mclk      (mclk),
      .sclk      (sclk),
      .lrck      (lrck),
      .adc_sdata (adc_sdata),
      .dac_sdata (dac_sdata),
      .rx_l      (rx_l),
      .rx_r      (rx_r),
      .rx_valid  (rx_valid),
      .tx_l      (tx_l),
      .tx_r      (tx_r),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .underrun  (underrun)
   );

   // Reference frame position: clk100 ticks since the last enable, wrapping every 2048.
   always @(posedge clk100) begin
      cur = (rst || !en) ? 0 : (cur + 1) % FRAME;
   end

   // Clocks follow fixed divide ratios of the frame position; rx/underrun pulses land at fixed points.
   always @(negedge clk100) begin
      if (check_on) begin
         if (mclk !== (((cur / 2) % 2) == 1))    clk_err++;
         if (sclk !== (((cur / 16) % 2) == 1))   clk_err++;
         if (lrck !== (((cur / 1024) % 2) == 1)) clk_err++;
         if (rx_valid === 1'b1) begin
            rx_seen++;
            if (cur != RX_DONE_CNT) rx_err++;
            if (rx_exp.size() == 0) begin
               rx_err++;
            end else begin
               rx_want = rx_exp.pop_front();
               if ({rx_l, rx_r} !== rx_want) rx_err++;
            end
         end else if (rx_valid !== 1'b0) begin
            rx_err++;
         end
         if (underrun === 1'b1) begin
            ur_seen++;
            if (cur != 1) ur_err++;
         end else if (underrun !== 1'b0) begin
            ur_err++;
         end
      end
   end

   // ADC model: new bit after each SCLK fall, delay slot after every LRCK edge, MSB first.
   always @(negedge sclk) begin
      if (model_on) begin
         #1;
         if (lrck !== adc_half) begin
            adc_pos  = 0;
            adc_half = lrck;
            if (lrck == 1'b0) adc_frame++;
         end else begin
            adc_pos++;
         end
         if (adc_pos >= 1 && adc_pos <= DATA_W) begin
            adc_sdata = adc_half ? adc_r_words[adc_frame % 8][DATA_W - adc_pos]
                                 : adc_l_words[adc_frame % 8][DATA_W - adc_pos];
         end else begin
            adc_sdata = 1'b0;
         end
      end
   end

   // DAC decoder: samples on SCLK rise, collects complete stereo words only.
   always @(posedge sclk) begin
      if (model_on) begin
         if (lrck !== dac_half) begin
            dac_pos  = 0;
            dac_half = lrck;
         end else begin
            dac_pos++;
         end
         if (dac_pos >= 1 && dac_pos <= DATA_W) begin
            if (dac_half) dac_rw[DATA_W - dac_pos] = dac_sdata;
            else          dac_lw[DATA_W - dac_pos] = dac_sdata;
         end else if (dac_sdata !== 1'b0) begin
            zero_err++;
         end
         if (dac_half && dac_pos == DATA_W) dac_got.push_back({dac_lw, dac_rw});
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      tests++;
      assert (observed === expected) else begin
         failed++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
      tx_valid = valid;
      tx_l     = l;
      tx_r     = r;
   endtask

   task automatic waitCnt(input int target, input string tag);
      bit hit = 1'b0;
      for (int i = 0; i < 2 * FRAME + 64; i++) begin
         @(negedge clk100);
         if (cur == target) begin
            hit = 1'b1;
            break;
         end
      end
      checkOutput({"reach_", tag}, 64'(hit), 64'd1);
   endtask

   logic [DATA_W-1:0] w_l [5];
   logic [DATA_W-1:0] w_r [5];
   logic [2*DATA_W-1:0] got;

   initial begin
      w_l[0] = 24'hA5A5A5;
      w_r[0] = 24'h0F0F0F;
      for (int i = 1; i < 5; i++) begin
         w_l[i] = DATA_W'($urandom);
         w_r[i] = DATA_W'($urandom);
      end
      adc_l_words[0] = 24'h555555;
      adc_r_words[0] = 24'h123456;
      for (int i = 1; i < 8; i++) begin
         adc_l_words[i] = DATA_W'($urandom);
         adc_r_words[i] = DATA_W'($urandom);
      end
      for (int i = 0; i < 8; i++) begin
         if (i != 6) rx_exp.push_back({adc_l_words[i], adc_r_words[i]});
      end
      dac_exp.push_back({w_l[0], w_r[0]});
      dac_exp.push_back({w_l[1], w_r[1]});
      dac_exp.push_back({w_l[2], w_r[2]});
      dac_exp.push_back('0);
      dac_exp.push_back('0);
      dac_exp.push_back('0);
      dac_exp.push_back({w_l[4], w_r[4]});

      repeat (10) @(posedge clk100);
      @(negedge clk100);
      checkOutput("reset_mclk",     64'(mclk),      64'd0);
      checkOutput("reset_sclk",     64'(sclk),      64'd0);
      checkOutput("reset_lrck",     64'(lrck),      64'd0);
      checkOutput("reset_dac",      64'(dac_sdata), 64'd0);
      checkOutput("reset_rx_valid", 64'(rx_valid),  64'd0);
      checkOutput("reset_underrun", 64'(underrun),  64'd0);
      checkOutput("reset_rx",       64'({rx_l, rx_r}), 64'd0);
      checkOutput("reset_tx_ready", 64'(tx_ready),  64'd1);
      check_on = 1'b1;
      rst      = 1'b0;

      applyStimulus(1'b1, w_l[0], w_r[0]);
      @(negedge clk100);
      checkOutput("tx_ready_after_accept", 64'(tx_ready), 64'd0);
      applyStimulus(1'b0, DATA_W'($urandom), DATA_W'($urandom));
      model_on = 1'b1;
      en       = 1'b1;

      waitCnt(1, "f1_start");
      checkOutput("f1_tx_ready_rise", 64'(tx_ready), 64'd1);
      checkOutput("f1_no_underrun",   64'(underrun), 64'd0);

      waitCnt(100, "bp_offer");
      applyStimulus(1'b1, w_l[1], w_r[1]);
      @(negedge clk100);
      applyStimulus(1'b1, w_l[2], w_r[2]);
      checkOutput("bp_first_taken", 64'(tx_ready), 64'd0);
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk100);
         if (tx_ready === 1'b1) break;
      end
      checkOutput("bp_second_ready_at", 64'(cur), 64'd1);
      @(negedge clk100);
      applyStimulus(1'b0, DATA_W'($urandom), DATA_W'($urandom));
      checkOutput("bp_second_taken", 64'(tx_ready), 64'd0);

      waitCnt(0, "f3");
      waitCnt(0, "f4");
      waitCnt(0, "f5");
      waitCnt(0, "f6");
      checkOutput("coinc_ready", 64'(tx_ready), 64'd1);
      applyStimulus(1'b1, w_l[3], w_r[3]);
      @(negedge clk100);
      applyStimulus(1'b0, DATA_W'($urandom), DATA_W'($urandom));
      checkOutput("coinc_held",     64'(tx_ready), 64'd0);
      checkOutput("coinc_underrun", 64'(underrun), 64'd1);

      waitCnt(0, "f7");
      waitCnt(1, "f7_start");
      checkOutput("f7_tx_ready",    64'(tx_ready), 64'd1);
      checkOutput("f7_no_underrun", 64'(underrun), 64'd0);
      waitCnt(200, "f7_offer");
      applyStimulus(1'b1, w_l[4], w_r[4]);
      @(negedge clk100);
      applyStimulus(1'b0, DATA_W'($urandom), DATA_W'($urandom));
      checkOutput("f7_hold_full", 64'(tx_ready), 64'd0);

      waitCnt(1024 + 10 * 32 + 24, "abort");
      en = 1'b0;
      @(negedge clk100);
      checkOutput("abort_mclk", 64'(mclk), 64'd0);
      checkOutput("abort_sclk", 64'(sclk), 64'd0);
      checkOutput("abort_lrck", 64'(lrck), 64'd0);
      repeat (40) @(negedge clk100);
      checkOutput("abort_hold_kept", 64'(tx_ready), 64'd0);
      en = 1'b1;

      waitCnt(1, "f8_start");
      checkOutput("f8_no_underrun", 64'(underrun), 64'd0);
      checkOutput("f8_tx_ready",    64'(tx_ready), 64'd1);
      waitCnt(1900, "f8_end");
      repeat (8) @(negedge clk100);

      checkOutput("clock_waveforms",  64'(clk_err),  64'd0);
      checkOutput("rx_pulse_count",   64'(rx_seen),  64'd7);
      checkOutput("rx_data_timing",   64'(rx_err),   64'd0);
      checkOutput("underrun_count",   64'(ur_seen),  64'd3);
      checkOutput("underrun_timing",  64'(ur_err),   64'd0);
      checkOutput("dac_idle_slots",   64'(zero_err), 64'd0);
      checkOutput("dac_frame_count",  64'(dac_got.size()), 64'(dac_exp.size()));
      for (int i = 0; i < dac_exp.size(); i++) begin
         got = (i < dac_got.size()) ? dac_got[i] : '1;
         checkOutput($sformatf("dac_frame_%0d", i), 64'(got), 64'(dac_exp[i]));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
